// File: rtl/cont_datareceive_pingpong_pkg.sv
// Shared types and widths for the host-to-device ping-pong playback path.
package cont_datareceive_pingpong_pkg;

  localparam int DATA_W  = 16;
  localparam int COUNT_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_PLAY,
    ST_STALL,
    ST_DONE
  } rdState_e;

endpackage

// File: rtl/cont_datareceive_pingpong_bank_ram.sv
// One ping-pong bank: simple dual-port RAM with a registered read port.
// The read register is only loaded on a read, so it holds the last word
// fetched, and it clears on reset so the playback output starts at zero.
module pp_bank_ram
  import cont_datareceive_pingpong_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Host-side write port; contents survive reset and are qualified by FULL flags.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, one cycle of latency, holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cont_datareceive_pingpong.sv
// Ping-pong playback buffer: the host fills one bank through a pipe-in
// endpoint while the other bank is replayed at a paced rate downstream.
module cont_datareceive_pingpong
  import cont_datareceive_pingpong_pkg::*;
#(
  parameter int BLOCK_LEN  = 4096,
  parameter int PLAY_DIV   = 1,
  parameter int NUM_BLOCKS = 120
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EP_WRITE,
  input  logic [DATA_W-1:0]  DATA_IN,
  input  logic               START,
  output logic               EP_READY,
  output logic [DATA_W-1:0]  DATA_OUT,
  output logic               DATA_VALID,
  output logic               UNDERRUN,
  output logic               OVERRUN,
  output logic               DONE,
  output logic [COUNT_W-1:0] BLOCK_COUNT
);

  localparam int AW = $clog2(BLOCK_LEN);
  localparam int PW = (PLAY_DIV > 1) ? $clog2(PLAY_DIV) : 1;
  localparam logic [AW-1:0]      LAST_ADDR  = AW'(BLOCK_LEN - 1);
  localparam logic [PW-1:0]      PACE_LAST  = PW'(PLAY_DIV - 1);
  localparam logic [COUNT_W-1:0] BLOCKS_MAX = COUNT_W'(NUM_BLOCKS);

  // Writer state
  logic [AW-1:0] wrAddr_q, wrAddr_d;
  logic          wrBank_q, wrBank_d;
  logic          epReady_q, epReady_d;
  logic          overrun_q, overrun_d;
  logic          wrAccept, wrComplete;

  // Bank ownership flags
  logic [1:0]    full_q, full_d;
  logic [1:0]    fullSet, fullClr, fullSeen;

  // Reader state
  rdState_e             state_q;
  logic [AW-1:0]        rdAddr_q;
  logic                 rdBank_q;
  logic                 outBank_q;
  logic [PW-1:0]        pace_q;
  logic                 dataValid_q;
  logic                 underrun_q;
  logic                 done_q;
  logic [COUNT_W-1:0]   blockCount_q;
  logic [COUNT_W-1:0]   blockCountNext;
  logic                 readIssue, lastWord, nextBankFull;

  logic [DATA_W-1:0]    rdata0, rdata1;

  // Writer next-state: accept only while ready, wrap and hand off the bank on its last word.
  always_comb begin
    wrAccept   = EP_WRITE && epReady_q;
    wrComplete = wrAccept && (wrAddr_q == LAST_ADDR);
    wrAddr_d   = wrAddr_q;
    wrBank_d   = wrBank_q;
    overrun_d  = overrun_q || (EP_WRITE && !epReady_q);
    if (wrAccept) begin
      wrAddr_d = wrComplete ? '0 : wrAddr_q + AW'(1);
    end
    if (wrComplete) begin
      wrBank_d = ~wrBank_q;
    end
    // Ready drops for the cycle after a block completes, then follows the new bank's flag.
    epReady_d = (state_q != ST_DONE) && !wrComplete && !full_q[wrBank_q];
  end

  // Flag bookkeeping; the reader sees a same-cycle completing write through fullSeen.
  always_comb begin
    fullSet  = 2'b00;
    fullClr  = 2'b00;
    if (wrComplete) begin
      fullSet[wrBank_q] = 1'b1;
    end
    if (lastWord) begin
      fullClr[rdBank_q] = 1'b1;
    end
    fullSeen = full_q | fullSet;
    full_d   = (full_q | fullSet) & ~fullClr;
  end

  // Reader pacing and block-boundary decode.
  always_comb begin
    readIssue      = (state_q == ST_PLAY) && (pace_q == '0);
    lastWord       = readIssue && (rdAddr_q == LAST_ADDR);
    nextBankFull   = rdBank_q ? fullSeen[0] : fullSeen[1];
    blockCountNext = (blockCount_q == BLOCKS_MAX) ? blockCount_q
                                                  : blockCount_q + COUNT_W'(1);
  end

  // Writer registers and sticky overrun.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wrAddr_q  <= '0;
      wrBank_q  <= 1'b0;
      epReady_q <= 1'b0;
      overrun_q <= 1'b0;
      full_q    <= 2'b00;
    end else begin
      wrAddr_q  <= wrAddr_d;
      wrBank_q  <= wrBank_d;
      epReady_q <= epReady_d;
      overrun_q <= overrun_d;
      full_q    <= full_d;
    end
  end

  // Reader FSM with registered playback outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      rdAddr_q     <= '0;
      rdBank_q     <= 1'b0;
      outBank_q    <= 1'b0;
      pace_q       <= '0;
      dataValid_q  <= 1'b0;
      underrun_q   <= 1'b0;
      done_q       <= 1'b0;
      blockCount_q <= '0;
    end else begin
      dataValid_q <= readIssue;
      done_q      <= (state_q == ST_DONE);
      if (readIssue) begin
        outBank_q <= rdBank_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_q <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          if (fullSeen[rdBank_q]) begin
            state_q <= ST_PLAY;
            pace_q  <= '0;
          end
        end
        ST_PLAY: begin
          pace_q <= (pace_q == PACE_LAST) ? '0 : pace_q + PW'(1);
          if (readIssue) begin
            rdAddr_q <= rdAddr_q + AW'(1);
          end
          if (lastWord) begin
            rdBank_q     <= ~rdBank_q;
            blockCount_q <= blockCountNext;
            if (blockCountNext == BLOCKS_MAX) begin
              state_q <= ST_DONE;
            end else if (!nextBankFull) begin
              underrun_q <= 1'b1;
              state_q    <= ST_STALL;
            end
          end
        end
        ST_STALL: begin
          if (fullSeen[rdBank_q]) begin
            state_q <= ST_PLAY;
            pace_q  <= '0;
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  pp_bank_ram #(
    .DEPTH (BLOCK_LEN),
    .AW    (AW)
  ) uBank0 (
    .clk     (CLK),
    .rst     (RST),
    .we_i    (wrAccept && !wrBank_q),
    .waddr_i (wrAddr_q),
    .wdata_i (DATA_IN),
    .re_i    (readIssue && !rdBank_q),
    .raddr_i (rdAddr_q),
    .rdata_o (rdata0)
  );

  pp_bank_ram #(
    .DEPTH (BLOCK_LEN),
    .AW    (AW)
  ) uBank1 (
    .clk     (CLK),
    .rst     (RST),
    .we_i    (wrAccept && wrBank_q),
    .waddr_i (wrAddr_q),
    .wdata_i (DATA_IN),
    .re_i    (readIssue && rdBank_q),
    .raddr_i (rdAddr_q),
    .rdata_o (rdata1)
  );

  assign EP_READY    = epReady_q;
  assign DATA_OUT    = outBank_q ? rdata1 : rdata0;
  assign DATA_VALID  = dataValid_q;
  assign UNDERRUN    = underrun_q;
  assign OVERRUN     = overrun_q;
  assign DONE        = done_q;
  assign BLOCK_COUNT = blockCount_q;

endmodule
